keystone_ctrl: RTL and testbench
================================

// Module: keystone_ctrl
// PURPOSE
//  Controls the keystone-correction datapath that sits in front of the piano renderer.
//  Turns user angle-adjust key presses into a saturating angle register.
//  Commits a new angle only at frame boundaries, so a frame never tears.
//  At the start of every video line, computes the horizontal shift magnitude for that line
//  with a sequential shift-add multiplier. The keystone datapath adds or subtracts this shift
//  about PIANO_MIDDLE.
// PARAMETERS
//  ANGLE_INIT   20   angle loaded on reset
//  ANGLE_MIN    0    lower saturation bound of angle
//  ANGLE_MAX    63   upper saturation bound of angle
//  REF_ROW      576  row with zero shift (KEY_START_VERTICAL + WHITE_KEY_HEIGHT)
//  FRAC_BITS    6    right shift applied to the product (fixed-point slope)
//  SHIFT_MAX    511  clamp for line_shift
//  UP_BIT       15   key_num bit that requests angle+1
//  DN_BIT       14   key_num bit that requests angle-1
// PORTS
//  clk           in   1   pixel clock (65 MHz domain)
//  reset         in   1   asynchronous, active-low reset
//  key_num       in   17  decoded key-press vector from the keyboard front end (level)
//  vsync         in   1   vertical sync, active-low; its falling edge marks the frame boundary
//  hsync         in   1   horizontal sync, active-low; its falling edge starts the line computation
//  vcount        in   10  current row; sampled on the hsync falling edge
//  angle         out  7   committed angle used for the current frame
//  line_shift    out  10  shift magnitude for the next line; held until the next valid
//  shift_valid   out  1   one-cycle pulse when line_shift updates
//  busy          out  1   high while the multiplier runs
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - angle = pending = ANGLE_INIT; line_shift = 0; shift_valid = 0; busy = 0; FSM = IDLE.
//   - All edge-detect history registers clear to 0.
//  Input conditioning:
//   - UP_BIT and DN_BIT of key_num each pass through a 2-flop synchronizer,
//     then a rising-edge detector.
//   - vsync and hsync pass through a 1-flop delay for falling-edge detection.
//  Pending angle update (any cycle):
//   - up edge only: pending = min(pending+1, ANGLE_MAX).
//   - dn edge only: pending = max(pending-1, ANGLE_MIN).
//   - Both edges in the same cycle: no change.
//   - Saturation is silent; no wrap.
//  Commit: on a vsync falling edge, angle <= pending (1-cycle latency).
//  Line FSM states: IDLE, LOAD, MUL, CLAMP.
//   - IDLE -> LOAD on hsync falling edge.
//     - Latch d = REF_ROW - vcount as 11-bit signed.
//     - If d <= 0, force d = 0 (rows below the reference get no shift).
//   - LOAD -> MUL: acc = 0, mcand = d, mplier = angle. Takes 1 cycle.
//   - MUL: 7 cycles of shift-add, one multiplier bit per cycle, LSB first.
//     acc is 18 bits wide; it cannot overflow because 576*127 < 2^17.
//   - CLAMP: line_shift <= min(acc >> FRAC_BITS, SHIFT_MAX); shift_valid = 1 for 1 cycle; -> IDLE.
//   - Latency from hsync edge to shift_valid: 9 cycles. busy is high in LOAD, MUL and CLAMP.
//  Boundary conditions:
//   - hsync edge while busy: ignored; the current computation completes.
//   - vsync commit during MUL: the multiplier keeps the angle latched in LOAD.
//     The new angle applies from the next line.
//   - reset mid-MUL: immediate abort. No shift_valid pulse. line_shift returns to 0.
//   - angle = 0: line_shift = 0 on every line.
// CONFIGURATION
//  KEYSTONE_AUTOREPEAT_EN
//   - Defined: a request bit held high (after the synchronizer) for 32 consecutive vsync
//     falling edges generates one step.
//   - After that first step it repeats a step every 8 further frames while held.
//   - Auto-repeat steps obey the same saturation rule and the same both-held-means-no-change rule.
//   - Not defined: only rising edges step; a held key steps exactly once.
// TESTING
//  1. Reset, then idle for one frame -> angle=20; first line with vcount=0 gives line_shift=(576*20)>>6=180.
//  2. Three UP pulses, then a vsync edge -> angle 20->23 only after the vsync edge; vcount=500 gives (76*23)>>6=27.
//  3. Hold UP through 100 rising edges with ANGLE_MAX=63, then a vsync edge -> angle=63, never wraps; DN x70 -> angle=0.
//  4. UP and DN rising in the same cycle -> pending unchanged; vcount=700 -> line_shift=0.
//  5. Second hsync edge 4 cycles into MUL -> exactly one shift_valid, 9 cycles after the first edge.
//  6. Assert reset during MUL -> busy=0 and line_shift=0 immediately; no shift_valid pulse.
//     With KEYSTONE_AUTOREPEAT_EN: hold UP for 48 frames -> +1 at the edge, +1 at frame 32, +1 at frame 40, +1 at frame 48.

Source files
------------

// File: rtl/keystone_ctrl.sv
// keystone_ctrl: angle register and per-line shift computation for the
// keystone-correction datapath in front of the piano renderer.
//
// User angle-adjust keys move a saturating pending angle; the pending angle is
// committed to the live angle at each vsync falling edge so a frame never tears.
// On each hsync falling edge the row distance from REF_ROW is multiplied by the
// committed angle with a 7-step sequential shift-add multiplier. The product is
// scaled by FRAC_BITS and clamped to SHIFT_MAX to give line_shift.
//
// Optional feature macro: KEYSTONE_AUTOREPEAT_EN. When defined, a held key
// steps once after 32 frames and then once every 8 further frames.
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | waiting for an hsync falling edge
// LOAD   | clear accumulator, load multiplicand/multiplier
// MUL    | 7 shift-add steps, multiplier LSB first
// CLAMP  | scale, clamp, publish line_shift with shift_valid pulse

module keystone_ctrl #(
  parameter int ANGLE_INIT = 20,
  parameter int ANGLE_MIN  = 0,
  parameter int ANGLE_MAX  = 63,
  parameter int REF_ROW    = 576,
  parameter int FRAC_BITS  = 6,
  parameter int SHIFT_MAX  = 511,
  parameter int UP_BIT     = 15,
  parameter int DN_BIT     = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [16:0] key_num,
  input  logic        vsync,
  input  logic        hsync,
  input  logic [9:0]  vcount,
  output logic [6:0]  angle,
  output logic [9:0]  line_shift,
  output logic        shift_valid,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MUL, S_CLAMP} state_t;

  state_t             state;
  logic [2:0]         up_sr;
  logic [2:0]         dn_sr;
  logic               vsync_d;
  logic               hsync_d;
  logic               up_edge;
  logic               dn_edge;
  logic               up_step;
  logic               dn_step;
  logic               vsync_fall;
  logic               hsync_fall;
  logic [6:0]         pending;
  logic [9:0]         d_reg;
  logic [17:0]        acc;
  logic [17:0]        mcand;
  logic [6:0]         mplier;
  logic [2:0]         step_cnt;
  logic signed [11:0] d_diff;
  logic [9:0]         d_clip;
  logic [17:0]        acc_scaled;
  logic               unused_keys;

  // Only the up/down request bits are consumed from the key vector.
  assign unused_keys = ^key_num;

  // Two synchronizer flops plus one history flop per key; one delay flop per sync.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_sr   <= 3'b000;
      dn_sr   <= 3'b000;
      vsync_d <= 1'b0;
      hsync_d <= 1'b0;
    end else begin
      up_sr   <= {up_sr[1:0], key_num[UP_BIT]};
      dn_sr   <= {dn_sr[1:0], key_num[DN_BIT]};
      vsync_d <= vsync;
      hsync_d <= hsync;
    end
  end

  assign up_edge    = up_sr[1] & ~up_sr[2];
  assign dn_edge    = dn_sr[1] & ~dn_sr[2];
  assign vsync_fall = vsync_d & ~vsync;
  assign hsync_fall = hsync_d & ~hsync;

`ifdef KEYSTONE_AUTOREPEAT_EN
  logic [4:0] up_hold;
  logic [4:0] dn_hold;
  logic       up_rep;
  logic       dn_rep;

  // The 32nd consecutive held frame edge steps; reloading 24 makes the next step 8 frames later.
  assign up_rep = vsync_fall & up_sr[1] & (up_hold == 5'd31);
  assign dn_rep = vsync_fall & dn_sr[1] & (dn_hold == 5'd31);

  // Count frame edges seen while each request is held; any release restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_hold <= 5'd0;
      dn_hold <= 5'd0;
    end else begin
      if (!up_sr[1])       up_hold <= 5'd0;
      else if (up_rep)     up_hold <= 5'd24;
      else if (vsync_fall) up_hold <= up_hold + 5'd1;
      if (!dn_sr[1])       dn_hold <= 5'd0;
      else if (dn_rep)     dn_hold <= 5'd24;
      else if (vsync_fall) dn_hold <= dn_hold + 5'd1;
    end
  end

  assign up_step = up_edge | up_rep;
  assign dn_step = dn_edge | dn_rep;
`else
  assign up_step = up_edge;
  assign dn_step = dn_edge;
`endif

  // Saturating pending angle; committed to the live angle on each frame boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 7'(ANGLE_INIT);
      angle   <= 7'(ANGLE_INIT);
    end else begin
      if (up_step && !dn_step) begin
        if (pending >= 7'(ANGLE_MAX)) pending <= 7'(ANGLE_MAX);
        else                          pending <= pending + 7'd1;
      end else if (dn_step && !up_step) begin
        if (pending <= 7'(ANGLE_MIN)) pending <= 7'(ANGLE_MIN);
        else                          pending <= pending - 7'd1;
      end
      if (vsync_fall) angle <= pending;
    end
  end

  // Rows at or below the reference row get no shift.
  assign d_diff     = $signed(12'(REF_ROW)) - $signed({2'b00, vcount});
  assign d_clip     = (d_diff <= 12'sd0) ? 10'd0 : d_diff[9:0];
  assign acc_scaled = acc >> FRAC_BITS;

  // Line FSM and shift-add multiplier; the angle is captured in LOAD and held for the line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      d_reg       <= 10'd0;
      acc         <= 18'd0;
      mcand       <= 18'd0;
      mplier      <= 7'd0;
      step_cnt    <= 3'd0;
      line_shift  <= 10'd0;
      shift_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      shift_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hsync_fall) begin
            d_reg <= d_clip;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          acc      <= 18'd0;
          mcand    <= {8'd0, d_reg};
          mplier   <= angle;
          step_cnt <= 3'd6;
          state    <= S_MUL;
        end
        S_MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (step_cnt == 3'd0) state <= S_CLAMP;
          else                  step_cnt <= step_cnt - 3'd1;
        end
        S_CLAMP: begin
          if (acc_scaled > 18'(SHIFT_MAX)) line_shift <= 10'(SHIFT_MAX);
          else                             line_shift <= acc_scaled[9:0];
          shift_valid <= 1'b1;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keystone_ctrl.sv
// Directed bench for keystone_ctrl (default build, auto-repeat disabled).
module tb_keystone_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] key_num;
  logic        vsync;
  logic        hsync;
  logic [9:0]  vcount;
  logic [6:0]  angle;
  logic [9:0]  line_shift;
  logic        shift_valid;
  logic        busy;

  int total = 0;
  int bad   = 0;

  keystone_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .key_num     (key_num),
    .vsync       (vsync),
    .hsync       (hsync),
    .vcount      (vcount),
    .angle       (angle),
    .line_shift  (line_shift),
    .shift_valid (shift_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key_pulse(input logic up, input logic dn);
    key_num[15] = up;
    key_num[14] = dn;
    repeat (4) tick();
    key_num = '0;
    repeat (4) tick();
  endtask

  task automatic frame_edge();
    vsync = 1'b0;
    repeat (3) tick();
    vsync = 1'b1;
    repeat (2) tick();
  endtask

  task automatic run_line(input logic [9:0] row, output int shift, output int lat);
    vcount = row;
    hsync  = 1'b0;
    tick();
    lat = 0;
    while (!shift_valid && lat < 30) begin
      if (lat == 2) hsync = 1'b1;
      tick();
      lat++;
    end
    shift = int'(line_shift);
    hsync = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    int sh, lat, pulses, at;
    reset   = 1'b0;
    key_num = '0;
    vsync   = 1'b1;
    hsync   = 1'b1;
    vcount  = '0;
    repeat (3) tick();
    chk("rst_angle", int'(angle), 20);
    chk("rst_shift", int'(line_shift), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(shift_valid), 0);
    reset = 1'b1;
    repeat (3) tick();

    // first frame at the reset angle
    frame_edge();
    chk("t1_angle", int'(angle), 20);
    run_line(10'd0, sh, lat);
    chk("t1_shift", sh, 180);
    chk("t1_latency", lat, 9);

    // three UP presses commit only at the frame edge
    repeat (3) key_pulse(1'b1, 1'b0);
    chk("t2_precommit", int'(angle), 20);
    frame_edge();
    chk("t2_angle", int'(angle), 23);
    run_line(10'd500, sh, lat);
    chk("t2_shift", sh, 27);

    // saturate high, then low
    repeat (100) key_pulse(1'b1, 1'b0);
    chk("t3_precommit", int'(angle), 23);
    frame_edge();
    chk("t3_angle_max", int'(angle), 63);
    run_line(10'd0, sh, lat);
    chk("t3_shift_clamp", sh, 511);
    repeat (70) key_pulse(1'b0, 1'b1);
    frame_edge();
    chk("t3_angle_min", int'(angle), 0);
    run_line(10'd0, sh, lat);
    chk("t3_shift_a0", sh, 0);
    run_line(10'd300, sh, lat);
    chk("t3_shift_a0b", sh, 0);

    // simultaneous UP and DN leaves pending alone
    repeat (5) key_pulse(1'b1, 1'b0);
    key_pulse(1'b1, 1'b1);
    frame_edge();
    chk("t4_angle", int'(angle), 5);
    run_line(10'd700, sh, lat);
    chk("t4_shift_below", sh, 0);
    run_line(10'd512, sh, lat);
    chk("t4_shift_512", sh, 5);

    // second hsync edge during MUL is ignored
    vcount = 10'd512;
    hsync  = 1'b0;
    tick();
    pulses = 0;
    at     = 0;
    sh     = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (shift_valid) begin
        pulses++;
        at = n;
        sh = int'(line_shift);
      end
      if (n == 3) chk("t5_busy_mul", int'(busy), 1);
      if (n == 1) hsync = 1'b1;
      if (n == 4) begin
        hsync  = 1'b0;
        vcount = 10'd0;
      end
      if (n == 6) hsync = 1'b1;
    end
    chk("t5_pulses", pulses, 1);
    chk("t5_at", at, 9);
    chk("t5_shift", sh, 5);
    chk("t5_busy_idle", int'(busy), 0);

    // reset mid-MUL aborts at once
    vcount = 10'd0;
    hsync  = 1'b0;
    tick();
    repeat (4) tick();
    hsync = 1'b1;
    reset = 1'b0;
    #1;
    chk("t6_busy", int'(busy), 0);
    chk("t6_shift", int'(line_shift), 0);
    chk("t6_valid", int'(shift_valid), 0);
    tick();
    reset = 1'b1;
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (shift_valid) pulses++;
    end
    chk("t6_no_pulse", pulses, 0);
    chk("t6_angle", int'(angle), 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
